s_memory_key_scheduler: RTL and testbench

Key-scheduling engine for the RC4 cracking datapath. It is the writer of the 256×8 S working memory: it fills S with the identity permutation, then runs the RC4 key-scheduling swap loop using a 24-bit secret key. When `finish` pulses, the keystream/decrypt stage can read S. The block shares the S RAM port with that stage through the top-level mux. The RAM has a registered address and 1-cycle read latency.

---
 rtl/rc4_pkg.sv | 34 +++
 rtl/s_memory_key_scheduler.sv | 152 +++++++++++++++
 tb/tb_s_memory_key_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 cracking datapath stages.
//   S_SIZE / S_LAST     : geometry of the 256x8 S working memory
//   KEY_LENGTH_DEFAULT  : default number of secret key bytes
//   ksa_state_t         : key-scheduling FSM encoding
// The state encoding reserves bit 4 as the RAM write strobe and bit 3 as the
// completion strobe. s_wren and finish are therefore straight copies of flop
// outputs, so they cannot glitch.
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int          S_SIZE             = 256;
  localparam logic [7:0]  S_LAST             = 8'd255;
  localparam int          KEY_LENGTH_DEFAULT = 3;

  localparam int          WREN_BIT           = 4;
  localparam int          FINISH_BIT         = 3;

  typedef enum logic [4:0] {
    IDLE       = 5'b00_000,
    READ_I     = 5'b00_001,
    WAIT_I     = 5'b00_010,
    UPDATE_J   = 5'b00_011,
    READ_J     = 5'b00_100,
    WAIT_J     = 5'b00_101,
    SWAP_SETUP = 5'b00_110,
    INIT_FILL  = 5'b10_000,
    WRITE_I    = 5'b10_001,
    WRITE_J    = 5'b10_010,
    DONE       = 5'b01_000
  } ksa_state_t;

endpackage

// File: rtl/s_memory_key_scheduler.sv
// -----------------------------------------------------------------------------
// s_memory_key_scheduler
// Writer of the 256x8 S working memory. It fills S with the identity
// permutation and then runs the RC4 key-scheduling swap loop. A one-cycle
// finish pulse marks S as ready for the keystream stage.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   start      : launch a run (honoured only in IDLE)
//   secret_key : big-endian key, byte 0 in the top 8 bits; captured at launch
//   s_address  : S RAM address (registered)
//   s_data     : S RAM write data (registered)
//   s_wren     : S RAM write enable
//   s_q        : S RAM read data (one cycle after the address is registered)
//   finish     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module s_memory_key_scheduler
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic [7:0]              s_address,
  output logic [7:0]              s_data,
  output logic                    s_wren,
  input  logic [7:0]              s_q,
  output logic                    finish
);

  localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  ksa_state_t              state_r;
  ksa_state_t              state_nxt_s;
  logic [8*KEY_LENGTH-1:0] key_r;
  logic [7:0]              addr_r;
  logic [7:0]              data_r;
  logic [7:0]              i_r;
  logic [7:0]              j_r;
  logic [7:0]              si_r;
  logic [KIW-1:0]          key_idx_r;
  logic [7:0]              key_byte_s;

  assign s_address = addr_r;
  assign s_data    = data_r;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:       state_nxt_s = start ? INIT_FILL : IDLE;
      INIT_FILL:  state_nxt_s = (addr_r == S_LAST) ? READ_I : INIT_FILL;
      READ_I:     state_nxt_s = WAIT_I;
      WAIT_I:     state_nxt_s = UPDATE_J;
      UPDATE_J:   state_nxt_s = READ_J;
      READ_J:     state_nxt_s = WAIT_J;
      WAIT_J:     state_nxt_s = SWAP_SETUP;
      SWAP_SETUP: state_nxt_s = WRITE_I;
      WRITE_I:    state_nxt_s = WRITE_J;
      WRITE_J:    state_nxt_s = (i_r == S_LAST) ? DONE : READ_I;
      DONE:       state_nxt_s = IDLE;
      default:    state_nxt_s = IDLE;
    endcase
  end

  // Strobe outputs taken straight from dedicated state bits
  always_comb begin
    s_wren = state_r[WREN_BIT];
    finish = state_r[FINISH_BIT];
  end

  // Key byte select: key_idx 0 is the most significant byte
  always_comb begin
    key_byte_s = 8'd0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      key_byte_s = (key_idx_r == KIW'(k)) ? key_r[8*(KEY_LENGTH-1-k) +: 8] : key_byte_s;
    end
  end

  // Datapath registers: address/data bus, indices, and the saved S[i]
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_r     <= '0;
      addr_r    <= 8'd0;
      data_r    <= 8'd0;
      i_r       <= 8'd0;
      j_r       <= 8'd0;
      si_r      <= 8'd0;
      key_idx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            key_r     <= secret_key;
            addr_r    <= 8'd0;
            data_r    <= 8'd0;
            i_r       <= 8'd0;
            j_r       <= 8'd0;
            key_idx_r <= '0;
          end
        end
        INIT_FILL: begin
          if (addr_r == S_LAST) begin
            i_r <= 8'd0;
          end else begin
            addr_r <= addr_r + 8'd1;
            data_r <= data_r + 8'd1;
          end
        end
        READ_I: addr_r <= i_r;
        UPDATE_J: begin
          si_r <= s_q;
          j_r  <= j_r + s_q + key_byte_s;
        end
        READ_J: addr_r <= j_r;
        SWAP_SETUP: begin
          // s_data itself holds S[j] for the WRITE_I cycle
          addr_r <= i_r;
          data_r <= s_q;
        end
        WRITE_I: begin
          addr_r <= j_r;
          data_r <= si_r;
        end
        WRITE_J: begin
          if (i_r != S_LAST) begin
            i_r       <= i_r + 8'd1;
            key_idx_r <= (key_idx_r == KIW'(KEY_LENGTH-1)) ? '0 : key_idx_r + KIW'(1);
          end
        end
        DONE: begin
          addr_r <= 8'd0;
          data_r <= 8'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_memory_key_scheduler.sv
// Bench for s_memory_key_scheduler: behavioural S RAM, software KSA model,
// write scoreboard checked by an independent monitor, plus hand vectors.
module tb_s_memory_key_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_wren;
  logic [7:0]  s_q;
  logic        finish;

  s_memory_key_scheduler #(.KEY_LENGTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .finish(finish)
  );

  always #5 clk = ~clk;

  // S RAM: registered address, one cycle read latency
  logic [7:0] mem [256];
  logic [7:0] ram_addr;
  always @(posedge clk) begin
    if (s_wren) mem[s_address] <= s_data;
    ram_addr <= s_address;
  end
  assign s_q = mem[ram_addr];

  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } wr_t;

  logic [15:0] exp_q [$];
  wr_t         wlog  [$];
  logic [7:0]  s_exp [256];
  int tests = 0, fails = 0;
  int ncyc = 0, wr_cnt = 0, finish_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every DUT write is popped against the scoreboard
  always @(negedge clk) begin
    ncyc++;
    if (s_wren) begin
      wr_t w;
      wr_cnt++;
      w.cyc = ncyc; w.a = s_address; w.d = s_data;
      wlog.push_back(w);
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {16'h0, s_address, s_data}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("write_stream", {16'h0, s_address, s_data}, {16'h0, e});
        end
      end
    end
    if (finish) finish_cnt++;
  end

  // Software RC4 KSA, producing the expected write stream and final S
  task automatic build_expected(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] j, a, b;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      s[k] = 8'(k);
      exp_q.push_back({8'(k), 8'(k)});
    end
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j = j + s[i] + kb[i % 3];
      a = s[i]; b = s[j];
      exp_q.push_back({8'(i), b});
      exp_q.push_back({j, a});
      s[i] = b; s[j] = a;
    end
    for (int k = 0; k < 256; k++) s_exp[k] = s[k];
  endtask

  task automatic run_key(input logic [23:0] key, input bit disturb);
    int cnt, fc0, nbad;
    bit got;
    build_expected(key);
    wlog.delete();
    chk_en = 1'b1;
    fc0 = finish_cnt;
    @(negedge clk); start = 1'b1; secret_key = key;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0; got = 1'b0;
    while (cnt < 3000 && !got) begin
      @(posedge clk); cnt++; #1;
      if (disturb) begin
        start = (cnt == 100 || cnt == 1500);
        if (cnt == 500) secret_key = ~key;
      end
      if (finish) got = 1'b1;
    end
    start = 1'b0;
    check("finish_latency", cnt, 2304);
    @(posedge clk); #1;
    check("finish_width", finish, 1'b0);
    check("idle_wren", s_wren, 1'b0);
    check("idle_addr", s_address, 8'd0);
    @(negedge clk);
    check("finish_pulses", finish_cnt - fc0, 1);
    check("writes_remaining", exp_q.size(), 0);
    check("write_count", wlog.size(), 768);
    if (wlog.size() >= 256) check("init_contiguous", wlog[255].cyc - wlog[0].cyc, 255);
    nbad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== s_exp[k]) nbad++;
    check("final_s_mismatches", nbad, 0);
    chk_en = 1'b0;
  endtask

  function automatic logic [15:0] wr_at(input int idx);
    if (idx < wlog.size()) return {wlog[idx].a, wlog[idx].d};
    return 16'hDEAD;
  endfunction

  initial begin
    int wc0, fc0;
    // Reset asserted together with start: reset must win
    reset_n = 1'b0; start = 1'b1; secret_key = 24'h0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_wren", s_wren, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_addr", s_address, 8'd0);
    check("rst_data", s_data, 8'd0);
    @(negedge clk); reset_n = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("idle_no_launch", s_wren, 1'b0);

    // Key 0x123456 with hand-computed swap writes
    run_key(24'h123456, 1'b0);
    check("it0_write_i", wr_at(256), 16'h0012);
    check("it0_write_j", wr_at(257), 16'h1200);
    check("it1_write_i", wr_at(258), 16'h0147);
    check("it1_write_j", wr_at(259), 16'h4701);
    check("it3_write_i", wr_at(262), 16'h03B4);
    check("it3_write_j", wr_at(263), 16'hB403);

    // All-zero key: i == j on iteration 0
    run_key(24'h000000, 1'b0);
    check("zero_it0_write_i", wr_at(256), 16'h0000);
    check("zero_it0_write_j", wr_at(257), 16'h0000);

    // Mid-run start pulses and key change must not disturb the run
    run_key(24'hA5F00F, 1'b1);

    // Reset in the middle of a run
    chk_en = 1'b0;
    @(negedge clk); start = 1'b1; secret_key = 24'h4B1D2E;
    @(posedge clk); #1 start = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    check("midrst_wren", s_wren, 1'b0);
    check("midrst_addr", s_address, 8'd0);
    check("midrst_finish", finish, 1'b0);
    @(negedge clk);
    wc0 = wr_cnt; fc0 = finish_cnt;
    repeat (2400) @(posedge clk);
    @(negedge clk);
    check("midrst_no_writes", wr_cnt - wc0, 0);
    check("midrst_no_finish", finish_cnt - fc0, 0);

    run_key(24'h4B1D2E, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
